// File: rtl/mux_4n_to_n_pkg.sv
// Shared types and constants for the 4:1 registered word selector.
package mux_4n_to_n_pkg;

  localparam int unsigned NUM_INPUTS = 4;
  localparam int unsigned SEL_W      = 2;

  // Select code to input mapping
  typedef enum logic [SEL_W-1:0] {
    SEL_I0 = 2'b00,
    SEL_I1 = 2'b01,
    SEL_I2 = 2'b10,
    SEL_I3 = 2'b11
  } sel_e;

endpackage : mux_4n_to_n_pkg

// File: rtl/mux_4n_to_n_if.sv
// Data/select bundle for mux_4n_to_n. P exists only when MUX4_PARITY_EN is defined.
interface mux_4n_to_n_if
  import mux_4n_to_n_pkg::*;
#(
  parameter int unsigned M = 4
);

  logic [M-1:0]     I0;
  logic [M-1:0]     I1;
  logic [M-1:0]     I2;
  logic [M-1:0]     I3;
  logic [SEL_W-1:0] S;
  logic [M-1:0]     O;
`ifdef MUX4_PARITY_EN
  logic             P;
`endif

  // Driver side: supplies words and select, observes the registered result
  modport master (
    output I0, I1, I2, I3, S,
`ifdef MUX4_PARITY_EN
    input  P,
`endif
    input  O
  );

  // Selector side
  modport slave (
    input  I0, I1, I2, I3, S,
`ifdef MUX4_PARITY_EN
    output P,
`endif
    output O
  );

endinterface : mux_4n_to_n_if

// File: rtl/mux_4n_to_n_comb.sv
// Purely combinational 4:1 word selection; unknown select codes give all-zero.
module mux_4n_to_n_comb
  import mux_4n_to_n_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic [M-1:0]     i0,
  input  logic [M-1:0]     i1,
  input  logic [M-1:0]     i2,
  input  logic [M-1:0]     i3,
  input  logic [SEL_W-1:0] sel,
  output logic [M-1:0]     word_c
);

  // Select one input word; the default branch keeps X/Z selects from propagating
  always_comb begin
    word_c = '0;
    case (sel)
      SEL_I0:  word_c = i0;
      SEL_I1:  word_c = i1;
      SEL_I2:  word_c = i2;
      SEL_I3:  word_c = i3;
      default: word_c = '0;
    endcase
  end

endmodule : mux_4n_to_n_comb

// File: rtl/mux_4n_to_n.sv
// Parameterised 4:1 multiplexer of M-bit words with a one-cycle registered output.
// Optional feature: define MUX4_PARITY_EN to add registered even-parity output P.
module mux_4n_to_n
  import mux_4n_to_n_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_4n_to_n_if.slave bus
);

  logic [M-1:0] sel_word_c;
  logic [M-1:0] o_q;

  mux_4n_to_n_comb #(
    .M (M)
  ) u_comb (
    .i0     (bus.I0),
    .i1     (bus.I1),
    .i2     (bus.I2),
    .i3     (bus.I3),
    .sel    (bus.S),
    .word_c (sel_word_c)
  );

  // Output word register; synchronous reset wins over the data path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q <= '0;
    end else begin
      o_q <= sel_word_c;
    end
  end

  assign bus.O = o_q;

`ifdef MUX4_PARITY_EN
  logic p_q;

  // Parity register tracks the same word as O so {O,P} has even parity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= 1'b0;
    end else begin
      p_q <= ^sel_word_c;
    end
  end

  assign bus.P = p_q;
`endif

endmodule : mux_4n_to_n

// File: tb/tb_mux_4n_to_n.sv
// Directed bench for mux_4n_to_n (M=4); parity checks included when MUX4_PARITY_EN is defined.
module tb_mux_4n_to_n;
  import mux_4n_to_n_pkg::*;

  localparam int unsigned M = 4;

  logic clk;
  logic rst_n;

  int unsigned vectors;
  int unsigned miscompares;

  mux_4n_to_n_if #(.M(M)) bus ();

  mux_4n_to_n #(.M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the output word against a hand-computed value
  task automatic check_o(input string tag, input logic [M-1:0] exp);
    vectors++;
    assert (bus.O === exp)
    else begin
      miscompares++;
      $error("FAIL %s: O observed %b expected %b", tag, bus.O, exp);
    end
  endtask

`ifdef MUX4_PARITY_EN
  // Compare the parity bit against a hand-computed value
  task automatic check_p(input string tag, input logic exp);
    vectors++;
    assert (bus.P === exp)
    else begin
      miscompares++;
      $error("FAIL %s: P observed %b expected %b", tag, bus.P, exp);
    end
  endtask
`endif

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held for two edges with S=11
    rst_n  = 1'b0;
    bus.I0 = 4'b0000;
    bus.I1 = 4'b0001;
    bus.I2 = 4'b0010;
    bus.I3 = 4'b0011;
    bus.S  = 2'b11;
    tick();
    check_o("rst_edge1", 4'b0000);
`ifdef MUX4_PARITY_EN
    check_p("rst_p_edge1", 1'b0);
`endif
    tick();
    check_o("rst_edge2", 4'b0000);
    rst_n = 1'b1;
    tick();
    check_o("rst_release", 4'b0011);

    // Select sweep, each select held four cycles
    bus.S = 2'b00;
    tick(); check_o("sweep_s00", 4'b0000);
    tick(); tick(); tick(); check_o("sweep_s00_hold", 4'b0000);
    bus.S = 2'b01;
    tick(); check_o("sweep_s01", 4'b0001);
    tick(); tick(); tick(); check_o("sweep_s01_hold", 4'b0001);
    bus.S = 2'b10;
    tick(); check_o("sweep_s10", 4'b0010);
    tick(); tick(); tick(); check_o("sweep_s10_hold", 4'b0010);
    bus.S = 2'b11;
    tick(); check_o("sweep_s11", 4'b0011);
    tick(); tick(); tick(); check_o("sweep_s11_hold", 4'b0011);

    // New data words, sweep again
    bus.I0 = 4'b0000;
    bus.I1 = 4'b1000;
    bus.I2 = 4'b0100;
    bus.I3 = 4'b1100;
    bus.S  = 2'b00;
    tick(); check_o("data_s00", 4'b0000);
    bus.S = 2'b01;
    tick(); check_o("data_s01", 4'b1000);
`ifdef MUX4_PARITY_EN
    check_p("par_1000", 1'b1);
`endif
    bus.S = 2'b11;
    tick(); check_o("data_s11", 4'b1100);
`ifdef MUX4_PARITY_EN
    check_p("par_1100", 1'b0);
`endif
    bus.S = 2'b10;
    tick(); check_o("data_s10", 4'b0100);
`ifdef MUX4_PARITY_EN
    check_p("par_0100", 1'b1);
`endif

    // Mid-interval data change is invisible until the next edge
    #1 bus.I2 = 4'b0110;
    #1 check_o("i2_change_before_edge", 4'b0100);
    tick(); check_o("i2_change_after_edge", 4'b0110);

    // Select glitch between edges: 10 -> 11 -> 00
    #1 bus.S = 2'b11;
    #1 check_o("glitch_s11_between", 4'b0110);
    #1 bus.S = 2'b00;
    #1 check_o("glitch_s00_between", 4'b0110);
    tick(); check_o("glitch_after_edge", 4'b0000);

    // Simultaneous change of select and data at the same instant
    bus.S  = 2'b11;
    bus.I3 = 4'b1010;
    tick(); check_o("simul_change", 4'b1010);
    bus.I3 = 4'b1100;

    // Reset mid-stream
    bus.S = 2'b01;
    tick(); check_o("mid_pre_rst", 4'b1000);
    rst_n = 1'b0;
    tick(); check_o("mid_rst", 4'b0000);
`ifdef MUX4_PARITY_EN
    check_p("mid_rst_p", 1'b0);
`endif
    rst_n = 1'b1;
    tick(); check_o("mid_rst_release", 4'b1000);
`ifdef MUX4_PARITY_EN
    check_p("mid_rst_release_p", 1'b1);
`endif

    // Output holds with unchanged inputs
    tick(); check_o("hold_final", 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux_4n_to_n
